// File: rtl/fifo_pkg.sv
// Shared constants and helper types for the single-clock FIFO.
// Instantiating blocks can import this package to pick up the default geometry.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Collapses the accepted push/pop pair into one operation code for the count update.
    function automatic fifo_op_e fifoOp(input logic wrOk, input logic rdOk);
        fifo_op_e op;
        case ({rdOk, wrOk})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so the array can map onto plain RAM.
module fifo_mem #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO: pointers, occupancy count, flags and a registered read port.
// A push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             we,
    input  logic             re,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic [WIDTH-1:0]  mem_rdata;
    logic              wr_ok, rd_ok;
    fifo_op_e          op;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign data_out   = data_out_q;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push alongside it.
    assign wr_ok = we & (~fifo_full | re);
    assign rd_ok = re & ~fifo_empty;
    assign op    = fifoOp(wr_ok, rd_ok);

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = mem_rdata;
        end

        case (op)
            OP_PUSH: count_d = count_q + CNT_W'(1);
            OP_POP:  count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed, table-driven bench for the FIFO: reset, fill, drain, concurrent, full push/pop, mid-op reset.
module tb_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic             rstN;
        logic             we;
        logic             re;
        logic [WIDTH-1:0] din;
        logic             expEmpty;
        logic             expFull;
        logic [WIDTH-1:0] expDout;
        string            tag;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] data_in;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] data_out;

    int   nApplied    = 0;
    int   nMiscompare = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .we         (we),
        .re         (re),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .data_out   (data_out)
    );

    function automatic void addVec(input logic rstN, input logic w, input logic r,
                                   input int din, input logic eEmpty, input logic eFull,
                                   input int eDout, input string tag);
        vec_t v;
        v.rstN     = rstN;
        v.we       = w;
        v.re       = r;
        v.din      = WIDTH'(din);
        v.expEmpty = eEmpty;
        v.expFull  = eFull;
        v.expDout  = WIDTH'(eDout);
        v.tag      = tag;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string tag, input logic eEmpty, input logic eFull,
                               input logic [WIDTH-1:0] eDout);
        nApplied++;
        if (fifo_empty !== eEmpty) begin
            nMiscompare++;
            $display("[TB] FAIL %s fifo_empty got %0b expected %0b", tag, fifo_empty, eEmpty);
        end
        if (fifo_full !== eFull) begin
            nMiscompare++;
            $display("[TB] FAIL %s fifo_full got %0b expected %0b", tag, fifo_full, eFull);
        end
        if (data_out !== eDout) begin
            nMiscompare++;
            $display("[TB] FAIL %s data_out got %0d expected %0d", tag, data_out, eDout);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst     = v.rstN;
        we      = v.we;
        re      = v.re;
        data_in = v.din;
        @(posedge clk);
        #1;
        checkOutput(v.tag, v.expEmpty, v.expFull, v.expDout);
    endtask

    initial begin
        rst     = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        data_in = '0;

        // Reset, then pops on an empty FIFO must change nothing.
        addVec(0, 0, 0, 0, 1, 0, 0, "reset");
        for (int i = 0; i < 8; i++)
            addVec(1, 0, 1, 0, 1, 0, 0, $sformatf("idleRead%0d", i));

        // Fill 1..8, then a write while full is dropped.
        for (int k = 1; k <= 8; k++)
            addVec(1, 1, 0, k, 0, (k == 8), 0, $sformatf("fill%0d", k));
        addVec(1, 1, 0, 9, 0, 1, 0, "fillOverflow");

        // Drain 1..8, then two reads on empty hold the last word.
        for (int k = 1; k <= 10; k++)
            addVec(1, 0, 1, 0, (k >= 8), 0, (k <= 8) ? k : 8, $sformatf("drain%0d", k));

        // Concurrent push/pop from empty: first cycle writes only, then one-cycle lag.
        addVec(1, 1, 1, 1, 0, 0, 8, "concFirst");
        for (int k = 2; k <= 8; k++)
            addVec(1, 1, 1, k, 0, 0, k - 1, $sformatf("conc%0d", k));
        addVec(1, 0, 1, 0, 1, 0, 8, "concTail");

        // Fill, push/pop while full, then drain across the pointer wrap.
        for (int k = 1; k <= 8; k++)
            addVec(1, 1, 0, k, 0, (k == 8), 8, $sformatf("refill%0d", k));
        addVec(1, 1, 1, 9, 0, 1, 1, "fullPushPop");
        for (int k = 2; k <= 9; k++)
            addVec(1, 0, 1, 0, (k == 9), 0, k, $sformatf("wrapDrain%0d", k));

        // Three words queued ahead of the mid-operation reset.
        for (int k = 10; k <= 12; k++)
            addVec(1, 1, 0, k, 0, 0, 9, $sformatf("preReset%0d", k));

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i]);

        // Reset pulsed between clock edges must take effect without waiting for a clock.
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        #2 rst = 1'b0;
        #1 checkOutput("midResetAsync", 1'b1, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("midResetRelease", 1'b1, 1'b0, '0);

        // Queued words are gone; the new word is the only one returned.
        vecs.delete();
        addVec(1, 1, 0, 5, 0, 0, 0, "postResetWrite");
        addVec(1, 0, 1, 0, 1, 0, 5, "postResetRead");
        addVec(1, 0, 1, 0, 1, 0, 5, "postResetHold");
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
